fpu_fmt_convert: RTL and testbench
==================================

Name: fpu_fmt_convert

Overview:
- Parametrised, pipelined IEEE-style float-to-float format converter for the FPU.
- Covers both widening (e.g. FP32->FP64) and narrowing (e.g. FP64->FP32) conversions, with rounding and exception flags.
- Two-stage pipeline with valid/ready handshake; sits between the FPU operand bus and the writeback mux.

Parameters:
- SRC_EW, 8, source exponent width.
- SRC_FW, 23, source fraction width (stored bits, excluding hidden bit).
- DST_EW, 11, destination exponent width.
- DST_FW, 52, destination fraction width.
- Legal configurations: (DST_EW>=SRC_EW and DST_FW>=SRC_FW) or (DST_EW<=SRC_EW and DST_FW<=SRC_FW). Any other combination is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  converter can accept input this cycle.
- in_data  in  1+SRC_EW+SRC_FW  source float {sign, exp, frac}.
- in_rm  in  1  rounding mode: 0 = RNE, 1 = RTZ; sampled with in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  1+DST_EW+DST_FW  converted float.
- out_flags  out  4  {invalid, overflow, underflow, inexact}, aligned with out_data.

Behaviour:
- Reset (async, reset_n=0): s1_valid, s2_valid, out_valid, out_data, out_flags, in_ready all 0. in_ready goes to 1 on the first clk after release. Reset mid-operation drops all in-flight words; no partial output.
- Handshake: transfer occurs when valid&ready.
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from the out_ready path).
  - out_valid/out_data must hold stable while out_ready=0.
- Latency: 2 cycles (accept at edge N, out_valid at edge N+2). Throughput: 1 per cycle. Order preserved; no loss or duplication under any back-pressure pattern.
- Stage 1 (unpack/classify):
  - Classify the input as zero, subnormal, normal, inf, qNaN or sNaN. qNaN is MSB of frac = 1.
  - Rebias: e' = e - bias_src + bias_dst, computed in max(SRC_EW,DST_EW)+2 signed bits.
  - Widening: left-align the fraction.
  - Narrowing: capture the kept fraction, guard bit (top dropped bit) and sticky (OR of the remaining dropped bits).
- Stage 2 (round/pack):
  - RNE increments when guard & (sticky | lsb).
  - RTZ never increments.
  - A fraction carry-out increments the exponent.
- Special cases (sign always preserved):
  - Zero in: signed zero out, no flags.
  - Subnormal in: flushed to signed zero, no flags.
  - Inf in: signed Inf out.
  - NaN in: exp all-ones; frac = source frac left-aligned (widening) or truncated (narrowing); quiet bit forced to 1.
    - sNaN additionally sets invalid.
    - If a truncated NaN frac would be zero, it stays nonzero via the quiet bit.
- Narrowing range checks:
  - e' >= max_dst_exp after rounding: overflow=1, inexact=1. Result is Inf under RNE, or max finite (exp=all-ones-1, frac=all-ones) under RTZ.
  - e' <= 0: output signed zero (FTZ); underflow=1, inexact=1.
  - Otherwise inexact = guard|sticky.
- Widening is always exact; only invalid can be set.
- Flags are per-result and non-sticky; accumulation is done by the FPU status register.

Decomposition:
- Package fpu_conv_pkg:
  - rounding-mode constants RM_RNE=0 and RM_RTZ=1;
  - flag bit indices FLG_INV=3, FLG_OVF=2, FLG_UNF=1, FLG_NX=0;
  - class enum fp_class_t {ZERO, SUB, NORM, INF, QNAN, SNAN};
  - bias helper function bias(ew) = 2^(ew-1)-1.
- One sub-module: fpu_conv_round, a purely combinational block in stage 2.
  - Inputs: kept frac, guard, sticky, rm.
  - Outputs: rounded frac, carry, inexact.

Test Plan:
- Default params, in_data 0x3F800000 and 0xC0490FDB, out_ready=1 -> out_data 0x3FF0000000000000 and 0xC00921FB60000000 two cycles after each accept; flags 0.
- Default params: 0x7F800001 (sNaN) -> 0x7FF8000020000000, invalid=1. Also 0x80000001 (subnormal) -> 0x8000000000000000, flags 0.
- Narrowing instance (11/52->8/23), 0x3FF0000010000000:
  - RNE -> 0x3F800000, inexact=1;
  - RTZ -> 0x3F800000, inexact=1.
- Narrowing instance, 0x47EFFFFFF0000000:
  - RNE -> 0x7F800000 with overflow+inexact;
  - RTZ -> 0x7F7FFFFF with overflow+inexact.
- Narrowing instance, 0x3690000000000000 (below FP32 min normal) -> 0x00000000, underflow+inexact.
- Back-pressure: stream 4 words with out_ready=0 for 3 cycles.
  - in_ready falls after 2 accepts; out_data is stable while stalled.
  - After out_ready=1, all 4 results emerge in order.
  - Then pull reset_n low while out_valid=1: out_valid=0 immediately, and nothing emerges after release.

Source files
------------

// File: rtl/fpu_fmt_convert_pkg.sv
// Shared constants and types for the float-to-float format converter.
package fpu_conv_pkg;

   localparam logic RM_RNE = 1'b0;
   localparam logic RM_RTZ = 1'b1;

   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_NX  = 0;

   typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_t;

   function automatic int bias(input int ew);
      return (1 << (ew - 1)) - 1;
   endfunction

endpackage

// File: rtl/fpu_fmt_convert_if.sv
// Operand-side and writeback-side handshake bundle of the format converter.
interface fpu_fmt_convert_if #(
   parameter int SRC_W = 32,
   parameter int DST_W = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [SRC_W-1:0] in_data;
   logic             in_rm;
   logic             out_valid;
   logic             out_ready;
   logic [DST_W-1:0] out_data;
   logic [3:0]       out_flags;

   modport master (
      output in_valid, in_data, in_rm, out_ready,
      input  in_ready, out_valid, out_data, out_flags
   );

   modport slave (
      input  in_valid, in_data, in_rm, out_ready,
      output in_ready, out_valid, out_data, out_flags
   );
endinterface

// File: rtl/fpu_conv_round.sv
// Round-to-nearest-even / truncate of a kept fraction given its guard and sticky bits.
module fpu_conv_round
   import fpu_conv_pkg::*;
#(
   parameter int FW = 23
) (
   input  logic [FW-1:0] frac,
   input  logic          guard,
   input  logic          sticky,
   input  logic          rm,
   output logic [FW-1:0] frac_rnd,
   output logic          carry,
   output logic          inexact
);

   logic inc;

   assign inc                = (rm == RM_RNE) && guard && (sticky || frac[0]);
   assign {carry, frac_rnd}  = {1'b0, frac} + (FW + 1)'(inc);
   assign inexact            = guard | sticky;

endmodule

// File: rtl/fpu_fmt_convert.sv
// Two-stage float format converter: stage 1 unpacks/rebiases, stage 2 rounds/packs into the output register.
module fpu_fmt_convert
   import fpu_conv_pkg::*;
#(
   parameter int SRC_EW = 8,
   parameter int SRC_FW = 23,
   parameter int DST_EW = 11,
   parameter int DST_FW = 52
) (
   input logic             clk,
   input logic             reset_n,
   fpu_fmt_convert_if.slave bus
);

   localparam int EW_I = ((SRC_EW > DST_EW) ? SRC_EW : DST_EW) + 2;
   localparam int DW   = 1 + DST_EW + DST_FW;
   localparam bit WIDEN  = (DST_EW >= SRC_EW) && (DST_FW >= SRC_FW);
   localparam bit NARROW = (DST_EW <= SRC_EW) && (DST_FW <= SRC_FW);

   localparam logic signed [EW_I-1:0] REBIAS    = EW_I'(bias(DST_EW) - bias(SRC_EW));
   localparam logic signed [EW_I-1:0] EXP_MAX   = EW_I'((1 << DST_EW) - 1);
   localparam logic signed [EW_I-1:0] EXP_ZERO  = '0;
   localparam logic [DST_FW-1:0]      QBIT      = {1'b1, {(DST_FW-1){1'b0}}};

   generate
      if (!(WIDEN || NARROW)) begin : g_bad_cfg
         $error("fpu_fmt_convert: exponent and fraction must both widen or both narrow");
      end
   endgenerate

   logic s1_adv, s2_adv, accept, rdy_q;
   logic s1_valid, s2_valid;

   logic              in_sign;
   logic [SRC_EW-1:0] in_exp;
   logic [SRC_FW-1:0] in_frac;
   fp_class_t         in_cls;
   logic signed [EW_I-1:0] in_ereb;
   logic [DST_FW-1:0] in_kept;
   logic              in_guard, in_sticky;

   logic              s1_sign, s1_guard, s1_sticky, s1_rm;
   fp_class_t         s1_cls;
   logic signed [EW_I-1:0] s1_exp;
   logic [DST_FW-1:0] s1_frac;

   logic [DST_FW-1:0] rnd_frac;
   logic              rnd_carry, rnd_nx, rne_carry;
   logic signed [EW_I-1:0] exp_ovf;
   logic [DST_EW-1:0] exp_pack;
   logic [DW-1:0]     res_data, out_data_q;
   logic [3:0]        res_flags, out_flags_q;

   assign s2_adv       = !s2_valid || bus.out_ready;
   assign s1_adv       = !s1_valid || s2_adv;
   assign bus.in_ready = rdy_q && s1_adv;
   assign accept       = bus.in_valid && bus.in_ready;

   assign bus.out_valid = s2_valid;
   assign bus.out_data  = out_data_q;
   assign bus.out_flags = out_flags_q;

   assign {in_sign, in_exp, in_frac} = bus.in_data;
   assign in_ereb = $signed(EW_I'(in_exp)) + REBIAS;

   always_comb begin
      if (in_exp == '0)
         in_cls = (in_frac == '0) ? ZERO : SUB;
      else if (&in_exp)
         in_cls = (in_frac == '0) ? INF : (in_frac[SRC_FW-1] ? QNAN : SNAN);
      else
         in_cls = NORM;
   end

   generate
      if (WIDEN) begin : g_widen
         assign in_kept   = DST_FW'(in_frac) << (DST_FW - SRC_FW);
         assign in_guard  = 1'b0;
         assign in_sticky = 1'b0;
      end else begin : g_narrow
         // Two zero pads keep guard/sticky slices legal when one or no bits are dropped.
         logic [SRC_FW+1:0] frac_ext;
         assign frac_ext  = {in_frac, 2'b00};
         assign in_kept   = frac_ext[SRC_FW+1 -: DST_FW];
         assign in_guard  = frac_ext[SRC_FW+1-DST_FW];
         assign in_sticky = |frac_ext[SRC_FW-DST_FW:0];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdy_q     <= 1'b0;
         s1_valid  <= 1'b0;
         s1_sign   <= 1'b0;
         s1_cls    <= ZERO;
         s1_exp    <= '0;
         s1_frac   <= '0;
         s1_guard  <= 1'b0;
         s1_sticky <= 1'b0;
         s1_rm     <= RM_RNE;
      end else begin
         rdy_q <= 1'b1;
         if (s1_adv) begin
            s1_valid <= accept;
            if (accept) begin
               s1_sign   <= in_sign;
               s1_cls    <= in_cls;
               s1_exp    <= in_ereb;
               s1_frac   <= in_kept;
               s1_guard  <= in_guard;
               s1_sticky <= in_sticky;
               s1_rm     <= bus.in_rm;
            end
         end
      end
   end

   fpu_conv_round #(.FW(DST_FW)) u_round (
      .frac     (s1_frac),
      .guard    (s1_guard),
      .sticky   (s1_sticky),
      .rm       (s1_rm),
      .frac_rnd (rnd_frac),
      .carry    (rnd_carry),
      .inexact  (rnd_nx)
   );

   // Overflow is judged on the nearest-rounded magnitude, so RTZ still flags values past max finite.
   assign rne_carry = s1_guard && (s1_sticky || s1_frac[0]) && (&s1_frac);
   assign exp_ovf   = s1_exp + $signed(EW_I'(rne_carry));
   assign exp_pack  = s1_exp[DST_EW-1:0] + DST_EW'(rnd_carry);

   always_comb begin
      res_data  = '0;
      res_flags = '0;
      case (s1_cls)
         ZERO, SUB: res_data = {s1_sign, {(DW-1){1'b0}}};
         INF:       res_data = {s1_sign, {DST_EW{1'b1}}, {DST_FW{1'b0}}};
         QNAN, SNAN: begin
            res_data           = {s1_sign, {DST_EW{1'b1}}, s1_frac | QBIT};
            res_flags[FLG_INV] = (s1_cls == SNAN);
         end
         default: begin
            if (s1_exp <= EXP_ZERO) begin
               res_data           = {s1_sign, {(DW-1){1'b0}}};
               res_flags[FLG_UNF] = 1'b1;
               res_flags[FLG_NX]  = 1'b1;
            end else if (exp_ovf >= EXP_MAX) begin
               res_flags[FLG_OVF] = 1'b1;
               res_flags[FLG_NX]  = 1'b1;
               if (s1_rm == RM_RTZ)
                  res_data = {s1_sign, {(DST_EW-1){1'b1}}, 1'b0, {DST_FW{1'b1}}};
               else
                  res_data = {s1_sign, {DST_EW{1'b1}}, {DST_FW{1'b0}}};
            end else begin
               res_data          = {s1_sign, exp_pack, rnd_frac};
               res_flags[FLG_NX] = rnd_nx;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid    <= 1'b0;
         out_data_q  <= '0;
         out_flags_q <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_data_q  <= res_data;
            out_flags_q <= res_flags;
         end
      end
   end

endmodule

// File: tb/tb_fpu_fmt_convert.sv
// Bench for fpu_fmt_convert: FP32->FP64 and FP64->FP32 instances against value-level reference models.
module tb_fpu_fmt_convert;
   import fpu_conv_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   fpu_fmt_convert_if #(.SRC_W(32), .DST_W(64)) wif ();
   fpu_fmt_convert_if #(.SRC_W(64), .DST_W(32)) nif ();

   fpu_fmt_convert u_widen (.clk(clk), .reset_n(reset_n), .bus(wif.slave));
   fpu_fmt_convert #(.SRC_EW(11), .SRC_FW(52), .DST_EW(8), .DST_FW(23))
      u_narrow (.clk(clk), .reset_n(reset_n), .bus(nif.slave));

   int n_checks = 0, n_pass = 0;
   int w_pops = 0, n_pops = 0, spurious = 0;
   logic [67:0] wq[$];
   logic [35:0] nq[$];
   logic [67:0] w_exp, w_hold_val;
   logic [35:0] n_exp, n_hold_val;
   logic w_acc = 0, n_acc = 0, w_pop = 0, n_pop = 0, w_hold = 0, n_hold = 0;

   task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Exact FP32 value rebuilt as a real, then taken as FP64 bits.
   function automatic logic [67:0] model_widen(input logic [31:0] x);
      logic s = x[31];
      int e = int'(x[30:23]);
      logic [22:0] f = x[22:0];
      real r;
      if (e == 0) return {4'h0, s, 63'h0};
      if (e == 255) begin
         if (f == 0) return {4'h0, s, 11'h7FF, 52'h0};
         return {!f[22], 3'b000, s, 11'h7FF, 1'b1, f[21:0], 29'h0};
      end
      r = (1.0 + real'(f) / 8388608.0) * (2.0 ** (e - 127));
      if (s) r = -r;
      return {4'h0, $realtobits(r)};
   endfunction

   function automatic logic [35:0] model_narrow(input logic [63:0] x, input logic rm);
      logic s = x[63];
      int e = int'(x[62:52]);
      logic [51:0] f = x[51:0];
      longint sig, q, rem;
      int be;
      logic up;
      if (e == 0) return {4'h0, s, 31'h0};
      if (e == 2047) begin
         if (f == 0) return {4'h0, s, 8'hFF, 23'h0};
         return {!f[51], 3'b000, s, 8'hFF, 1'b1, f[50:29]};
      end
      be = e - 1023 + 127;
      if (be <= 0) return {4'b0011, s, 31'h0};
      sig = longint'({12'h001, f});
      q   = sig / 536870912;
      rem = sig % 536870912;
      up  = (rem > 268435456) || (rem == 268435456 && (q % 2) == 1);
      if (be + (((q + longint'(up)) >= 16777216) ? 1 : 0) >= 255)
         return {4'b0101, s, (rm ? 31'h7F7FFFFF : 31'h7F800000)};
      if (!rm && up) q = q + 1;
      if (q >= 16777216) begin
         q  = q / 2;
         be = be + 1;
      end
      return {3'b000, rem != 0, s, 8'(be), 23'(q % 8388608)};
   endfunction

   function automatic logic [31:0] rand_f32();
      int k = int'($urandom_range(0, 9));
      logic s = 1'($urandom_range(0, 1));
      logic [22:0] f = 23'($urandom);
      case (k)
         0: return {s, 31'h0};
         1: return {s, 8'h00, f | 23'h1};
         2: return {s, 8'hFF, 23'h0};
         3: return {s, 8'hFF, f | 23'h1};
         default: return {s, 8'($urandom_range(1, 254)), f};
      endcase
   endfunction

   function automatic logic [63:0] rand_f64();
      int k = int'($urandom_range(0, 11));
      logic s = 1'($urandom_range(0, 1));
      logic [51:0] f = 52'({$urandom, $urandom});
      case (k)
         0: return {s, 63'h0};
         1: return {s, 11'h000, f | 52'h1};
         2: return {s, 11'h7FF, 52'h0};
         3: return {s, 11'h7FF, f | 52'h1};
         4, 5: begin
            if ($urandom_range(0, 1) == 1) f[51:29] = '1;
            return {s, 11'($urandom_range(1149, 1152)), f};
         end
         6, 7: return {s, 11'($urandom_range(894, 898)), f};
         8: begin
            f[28:0] = 29'h10000000;
            return {s, 11'($urandom_range(900, 1150)), f};
         end
         default: return {s, 11'($urandom_range(1, 2046)), f};
      endcase
   endfunction

   // One cycle: sample just before the rising edge, then return on the next falling edge.
   task automatic tick();
      #4;
      w_acc = wif.in_valid && wif.in_ready;
      n_acc = nif.in_valid && nif.in_ready;
      w_pop = wif.out_valid && wif.out_ready;
      n_pop = nif.out_valid && nif.out_ready;
      if (w_acc) wq.push_back(w_exp);
      if (n_acc) nq.push_back(n_exp);
      if (w_hold) check_eq("w_stall_hold", {wif.out_valid, wif.out_flags, wif.out_data}, {1'b1, w_hold_val});
      if (n_hold) check_eq("n_stall_hold", {nif.out_valid, nif.out_flags, nif.out_data}, {1'b1, n_hold_val});
      w_hold = wif.out_valid && !wif.out_ready;
      n_hold = nif.out_valid && !nif.out_ready;
      w_hold_val = {wif.out_flags, wif.out_data};
      n_hold_val = {nif.out_flags, nif.out_data};
      if (w_pop) begin
         if (wq.size() == 0) spurious++;
         else begin
            check_eq("w_result", {wif.out_flags, wif.out_data}, wq.pop_front());
            w_pops++;
         end
      end
      if (n_pop) begin
         if (nq.size() == 0) spurious++;
         else begin
            check_eq("n_result", {nif.out_flags, nif.out_data}, nq.pop_front());
            n_pops++;
         end
      end
      @(negedge clk);
   endtask

   task automatic send_w(input logic [31:0] d, input logic rm, input logic [67:0] exp);
      int n = 0;
      wif.in_data = d; wif.in_rm = rm; wif.in_valid = 1'b1; w_exp = exp;
      do begin tick(); n++; end while (!w_acc && n < 20);
      check_eq("w_accept", w_acc, 1);
      wif.in_valid = 1'b0;
   endtask

   task automatic send_n(input logic [63:0] d, input logic rm, input logic [35:0] exp);
      int n = 0;
      nif.in_data = d; nif.in_rm = rm; nif.in_valid = 1'b1; n_exp = exp;
      do begin tick(); n++; end while (!n_acc && n < 20);
      check_eq("n_accept", n_acc, 1);
      nif.in_valid = 1'b0;
   endtask

   task automatic wait_pop(input bit narrow, input int want_lat);
      int n = 0;
      bit got;
      do begin
         tick(); n++;
         got = narrow ? n_pop : w_pop;
      end while (!got && n < 10);
      check_eq(narrow ? "n_latency" : "w_latency", n, want_lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [31:0] bp_words[4];
      int idx, pops0, g;

      wif.in_valid = 0; wif.in_data = '0; wif.in_rm = 0; wif.out_ready = 0;
      nif.in_valid = 0; nif.in_data = '0; nif.in_rm = 0; nif.out_ready = 0;
      w_exp = '0; n_exp = '0;
      reset_n = 1'b0;
      @(negedge clk); @(negedge clk);
      check_eq("rst_w_outputs", {wif.in_ready, wif.out_valid, wif.out_flags, wif.out_data}, '0);
      check_eq("rst_n_outputs", {nif.in_ready, nif.out_valid, nif.out_flags, nif.out_data}, '0);
      reset_n = 1'b1;
      #4;
      check_eq("rdy_before_first_clk", {wif.in_ready, nif.in_ready}, 2'b00);
      @(negedge clk);
      check_eq("rdy_after_first_clk", {wif.in_ready, nif.in_ready}, 2'b11);

      wif.out_ready = 1; nif.out_ready = 1;
      send_w(32'h3F800000, RM_RNE, {4'h0, 64'h3FF0000000000000}); wait_pop(0, 2);
      send_w(32'hC0490FDB, RM_RNE, {4'h0, 64'hC00921FB60000000}); wait_pop(0, 2);
      send_w(32'h7F800001, RM_RNE, {4'b1000, 64'h7FF8000020000000}); wait_pop(0, 2);
      send_w(32'h80000001, RM_RTZ, {4'h0, 64'h8000000000000000}); wait_pop(0, 2);
      send_n(64'h3FF0000010000000, RM_RNE, {4'b0001, 32'h3F800000}); wait_pop(1, 2);
      send_n(64'h3FF0000010000000, RM_RTZ, {4'b0001, 32'h3F800000}); wait_pop(1, 2);
      send_n(64'h47EFFFFFF0000000, RM_RNE, {4'b0101, 32'h7F800000}); wait_pop(1, 2);
      send_n(64'h47EFFFFFF0000000, RM_RTZ, {4'b0101, 32'h7F7FFFFF}); wait_pop(1, 2);
      send_n(64'h3690000000000000, RM_RNE, {4'b0011, 32'h00000000}); wait_pop(1, 2);

      // Back-pressure: four words into a stalled consumer.
      for (int i = 0; i < 4; i++) bp_words[i] = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      pops0 = w_pops; idx = 0;
      wif.out_ready = 0;
      for (int c = 0; c < 3; c++) begin
         wif.in_valid = 1; wif.in_data = bp_words[idx]; wif.in_rm = RM_RNE;
         w_exp = model_widen(bp_words[idx]);
         tick();
         if (w_acc) idx++;
      end
      check_eq("bp_accepts_while_stalled", idx, 2);
      check_eq("bp_in_ready_low", wif.in_ready, 0);
      wif.out_ready = 1;
      g = 0;
      while (idx < 4 && g < 20) begin
         wif.in_valid = 1; wif.in_data = bp_words[idx]; w_exp = model_widen(bp_words[idx]);
         tick(); g++;
         if (w_acc) idx++;
      end
      wif.in_valid = 0;
      g = 0;
      while (wq.size() > 0 && g < 20) begin tick(); g++; end
      check_eq("bp_drained", wq.size(), 0);
      check_eq("bp_pop_count", w_pops - pops0, 4);

      // Reset while a result is waiting at the output.
      wif.out_ready = 0;
      send_w(32'h40000000, RM_RNE, {4'h0, 64'h4000000000000000});
      send_w(32'h40400000, RM_RNE, {4'h0, 64'h4008000000000000});
      g = 0;
      while (!wif.out_valid && g < 10) begin tick(); g++; end
      check_eq("rst_pre_out_valid", wif.out_valid, 1);
      reset_n = 1'b0;
      #1;
      check_eq("rst_drops_out_valid", wif.out_valid, 0);
      wq.delete(); nq.delete(); w_hold = 0; n_hold = 0;
      @(negedge clk);
      reset_n = 1'b1;
      wif.out_ready = 1;
      pops0 = w_pops;
      repeat (6) tick();
      check_eq("rst_nothing_emerges", (w_pops - pops0) + spurious, 0);

      // Randomised traffic with random back-pressure on both instances.
      w_acc = 0; n_acc = 0;
      for (int c = 0; c < 600; c++) begin
         if (!wif.in_valid || w_acc) begin
            wif.in_valid = ($urandom_range(0, 9) < 7);
            wif.in_data  = rand_f32();
            wif.in_rm    = 1'($urandom_range(0, 1));
            w_exp        = model_widen(wif.in_data);
         end
         if (!nif.in_valid || n_acc) begin
            nif.in_valid = ($urandom_range(0, 9) < 7);
            nif.in_data  = rand_f64();
            nif.in_rm    = 1'($urandom_range(0, 1));
            n_exp        = model_narrow(nif.in_data, nif.in_rm);
         end
         wif.out_ready = ($urandom_range(0, 3) != 0);
         nif.out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      wif.in_valid = 0; nif.in_valid = 0;
      wif.out_ready = 1; nif.out_ready = 1;
      g = 0;
      while ((wq.size() > 0 || nq.size() > 0) && g < 20) begin tick(); g++; end
      check_eq("final_w_queue_empty", wq.size(), 0);
      check_eq("final_n_queue_empty", nq.size(), 0);
      check_eq("no_spurious_outputs", spurious, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
